// File: rtl/klp32_dmem_responder.sv
// KLP32 data-memory responder: req/ready handshake, WAIT_STATES wait cycles, RV32I byte/half/word access.
// Optional KLP32_DMEM_CLEAR_EN: asynchronous reset also zeroes the whole array.
module klp32_dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    output logic        o_ready,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } store_lanes_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic             eff_we;
    logic [31:0]      eff_addr;
    logic [31:0]      eff_wdata;
    logic [2:0]       eff_funct3;
    logic             eff_err;
    logic [IDX_W-1:0] idx;
    logic             enter_resp;
    logic             commit;
    store_lanes_t     lanes;

    function automatic logic access_err(input logic we, input logic [31:0] addr,
                                        input logic [2:0] funct3);
        logic bad;
        case (funct3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = addr[0];
            3'b010:  bad = (addr[1:0] != 2'b00);
            3'b100:  bad = we;
            3'b101:  bad = we | addr[0];
            default: bad = 1'b1;
        endcase
        return bad | (addr[31:2] >= 30'(DEPTH_WORDS));
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [2:0] funct3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return word;
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

    function automatic store_lanes_t store_place(input logic [31:0] wdata, input logic [1:0] lane,
                                                 input logic [2:0] funct3);
        store_lanes_t s;
        case (funct3)
            3'b000: begin
                s.be   = 4'b0001 << lane;
                s.data = {4{wdata[7:0]}};
            end
            3'b001: begin
                s.be   = lane[1] ? 4'b1100 : 4'b0011;
                s.data = {2{wdata[15:0]}};
            end
            default: begin
                s.be   = 4'b1111;
                s.data = wdata;
            end
        endcase
        return s;
    endfunction

    // With zero wait states the access happens on the accepting edge, before anything is latched,
    // so the datapath looks through to the live inputs while idle.
    always_comb begin
        if (state == ST_IDLE) begin
            eff_we     = i_we;
            eff_addr   = i_addr;
            eff_wdata  = i_wdata;
            eff_funct3 = i_funct3;
        end else begin
            eff_we     = we_q;
            eff_addr   = addr_q;
            eff_wdata  = wdata_q;
            eff_funct3 = funct3_q;
        end
    end

    assign eff_err    = access_err(eff_we, eff_addr, eff_funct3);
    assign idx        = eff_addr[IDX_W+1:2];
    assign enter_resp = (state_next == ST_RESP);
    assign commit     = enter_resp && eff_we && !eff_err;
    assign lanes      = store_place(eff_wdata, eff_addr[1:0], eff_funct3);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_req) state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
            end
            ST_WAIT: begin
                if (cnt == 4'd1) state_next = ST_RESP;
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
        end else if (state == ST_IDLE && i_req) begin
            cnt      <= 4'(WAIT_STATES);
            we_q     <= i_we;
            addr_q   <= i_addr;
            wdata_q  <= i_wdata;
            funct3_q <= i_funct3;
        end else if (state == ST_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

`ifdef KLP32_DMEM_CLEAR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
        end else if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes.be[b]) mem[idx][8*b +: 8] <= lanes.data[8*b +: 8];
            end
        end
    end
`else
    // NOTE: the array has no reset so it maps onto plain RAM; reset only blocks a commit.
    always_ff @(posedge clk) begin
        if (reset && commit) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes.be[b]) mem[idx][8*b +: 8] <= lanes.data[8*b +: 8];
            end
        end
    end
`endif

    // Response fields exist only during RESP; they are zero the rest of the time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            err_q   <= eff_err;
            rdata_q <= (eff_err || eff_we) ? 32'd0
                                           : load_extend(mem[idx], eff_addr[1:0], eff_funct3);
        end else begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end
    end

    assign o_ready  = (state == ST_IDLE);
    assign o_rvalid = (state == ST_RESP);
    assign o_rdata  = rdata_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_klp32_dmem_responder.sv
// Scoreboard bench for klp32_dmem_responder (WAIT_STATES=1): the driver queues expected responses, a monitor checks them.
module tb_klp32_dmem_responder;

    localparam int DEPTH_WORDS = 1024;
    localparam int WAIT_STATES = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_wdata = 32'd0;
    logic [2:0]  i_funct3 = 3'd0;
    logic        o_ready;
    logic        o_rvalid;
    logic [31:0] o_rdata;
    logic        o_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    klp32_dmem_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .WAIT_STATES(WAIT_STATES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_we    (i_we),
        .i_addr  (i_addr),
        .i_wdata (i_wdata),
        .i_funct3(i_funct3),
        .o_ready (o_ready),
        .o_rvalid(o_rvalid),
        .o_rdata (o_rdata),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every response strobe must match the oldest queued expectation and arrive on time.
    always @(negedge clk) begin
        if (reset && o_rvalid) begin
            if (q.size() == 0) begin
                check("unexpected_rvalid", 32'(o_rvalid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rdata", o_rdata, e.rdata);
                check("err", 32'(o_err), 32'(e.err));
                check("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Presents a request (left asserted afterwards) and queues its expected response on acceptance.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] funct3, input logic [31:0] exp_rdata,
                          input logic exp_err);
        bit accepted = 0;
        @(negedge clk);
        i_req    = 1'b1;
        i_we     = we;
        i_addr   = addr;
        i_wdata  = wdata;
        i_funct3 = funct3;
        for (int i = 0; i < 50 && !accepted; i++) begin
            if (o_ready) begin
                exp_t e;
                accepted = 1;
                e.rdata  = exp_rdata;
                e.err    = exp_err;
                e.cyc    = cyc + WAIT_STATES + 1;
                q.push_back(e);
            end else begin
                @(negedge clk);
            end
        end
        if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done = 0;
        @(negedge clk);
        i_req = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (q.size() == 0 && o_ready) done = 1;
            else @(negedge clk);
        end
        if (!done) check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(o_ready), 32'd1);
        check("reset_rvalid", 32'(o_rvalid), 32'd0);
        check("reset_rdata", o_rdata, 32'd0);
        check("reset_err", 32'(o_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Word store/load.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);

        // Byte merge and extension.
        do_req(1'b1, 32'h20, 32'h11223344, 3'b010, 32'h0, 1'b0);
        do_req(1'b1, 32'h21, 32'h00000080, 3'b000, 32'h0, 1'b0);
        do_req(1'b0, 32'h20, 32'h0, 3'b010, 32'h11228044, 1'b0);
        do_req(1'b0, 32'h21, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0);
        do_req(1'b0, 32'h21, 32'h0, 3'b100, 32'h00000080, 1'b0);
        do_req(1'b0, 32'h23, 32'h0, 3'b000, 32'h00000011, 1'b0);
        do_req(1'b0, 32'h20, 32'h0, 3'b001, 32'hFFFF8044, 1'b0);

        // Halfword store into the upper half of a known word.
        do_req(1'b1, 32'h30, 32'h00007777, 3'b010, 32'h0, 1'b0);
        do_req(1'b1, 32'h32, 32'h1234ABCD, 3'b001, 32'h0, 1'b0);
        do_req(1'b0, 32'h32, 32'h0, 3'b001, 32'hFFFFABCD, 1'b0);
        do_req(1'b0, 32'h32, 32'h0, 3'b101, 32'h0000ABCD, 1'b0);
        do_req(1'b0, 32'h30, 32'h0, 3'b010, 32'hABCD7777, 1'b0);

        // Rejected accesses, then confirm nothing was written.
        do_req(1'b0, 32'h22, 32'h0, 3'b010, 32'h0, 1'b1);
        do_req(1'b1, 32'h33, 32'hFFFFFFFF, 3'b001, 32'h0, 1'b1);
        do_req(1'b0, 32'(4 * DEPTH_WORDS), 32'h0, 3'b010, 32'h0, 1'b1);
        do_req(1'b1, 32'h20, 32'hFFFFFFFF, 3'b100, 32'h0, 1'b1);
        do_req(1'b0, 32'h20, 32'h0, 3'b011, 32'h0, 1'b1);
        do_req(1'b0, 32'h20, 32'h0, 3'b010, 32'h11228044, 1'b0);
        do_req(1'b0, 32'h30, 32'h0, 3'b010, 32'hABCD7777, 1'b0);
        do_req(1'b0, 32'(4 * DEPTH_WORDS - 4), 32'h0, 3'b111, 32'h0, 1'b1);
        drain();

        // Reset during WAIT of a store aborts it.
        do_req(1'b1, 32'h40, 32'h12345678, 3'b010, 32'h0, 1'b0);
        drain();
        @(negedge clk);
        i_req    = 1'b1;
        i_we     = 1'b1;
        i_addr   = 32'h40;
        i_wdata  = 32'h00000055;
        i_funct3 = 3'b010;
        for (int i = 0; i < 20 && !o_ready; i++) @(negedge clk);
        check("abort_accept_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        i_req = 1'b0;
        check("abort_in_wait", 32'(o_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("abort_ready", 32'(o_ready), 32'd1);
        check("abort_rvalid", 32'(o_rvalid), 32'd0);
        check("abort_rdata", o_rdata, 32'd0);
        check("abort_err", 32'(o_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
`ifdef KLP32_DMEM_CLEAR_EN
        do_req(1'b0, 32'h40, 32'h0, 3'b010, 32'h0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 3'b010, 32'h0, 1'b0);
`else
        do_req(1'b0, 32'h40, 32'h0, 3'b010, 32'h12345678, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);
`endif
        drain();
        repeat (3) @(negedge clk);

        check("leftover_expected", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/klp32_dmem_responder.md
Name: klp32_dmem_responder

Overview:
- Data-memory responder on the KLP32 core's load/store port; the core is the initiator.
- Accepts one request at a time over a req/ready handshake, inserts configurable wait states, performs byte/half/word access with RV32I load/store semantics, and returns a one-cycle response pulse.
- Sits between the core's memRW/ALU-address/regData2 path and the writeback mux; replaces the combinational data memory for multi-cycle memory builds.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; the byte address space is 0 .. 4*DEPTH_WORDS-1.
- WAIT_STATES, 1, extra cycles spent in WAIT before the response; legal range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_req  input  1  request valid; sampled only when o_ready=1.
- i_we  input  1  1 = store, 0 = load (core memRW).
- i_addr  input  32  byte address.
- i_wdata  input  32  store data, right-aligned (core regData2).
- i_funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- o_ready  output  1  responder idle and able to accept a request.
- o_rvalid  output  1  one-cycle response strobe, for loads and stores.
- o_rdata  output  32  load result, valid only while o_rvalid=1; 0 for stores and errors.
- o_err  output  1  qualifies o_rvalid; the access was rejected.

Behaviour:
- Reset (reset=0, async): state=IDLE, wait counter=0, o_ready=1, o_rvalid=0, o_rdata=0, o_err=0. Array contents are kept unless the optional feature is enabled. Reset mid-transaction aborts it; a pending store is not committed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - o_ready=1.
  - On i_req=1, latch addr, wdata, funct3 and we.
  - Load counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else go to RESP.
- WAIT:
  - o_ready=0.
  - Decrement counter; go to RESP on the edge where the counter reaches 1.
- RESP:
  - o_rvalid=1 for exactly one cycle, o_ready=0; next state IDLE.
  - o_rvalid rises WAIT_STATES+1 cycles after the accepting edge.
  - Back-to-back requests therefore have a throughput of one per WAIT_STATES+2 cycles.
- Store commit: the array write occurs on the edge entering RESP, only if there is no error.
- Load data: read from the latched address; a load issued right after a store to the same word returns the new data.
- Word index = addr[31:2]; byte lane = addr[1:0].
- Loads: select the lane and extend.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - LW returns the full word.
- Stores:
  - SB writes i_wdata[7:0] to lane addr[1:0].
  - SH writes i_wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
  - Unaddressed lanes are unchanged.
- Error conditions (o_err=1 with o_rvalid, no write, o_rdata=0):
  - Misaligned access: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - addr[31:2] >= DEPTH_WORDS.
  - funct3 in {011, 110, 111}.
  - Store with funct3 in {100, 101}.
- i_req while o_ready=0 is ignored; no queuing. The initiator must hold or re-present the request.
- i_* changes after acceptance have no effect on the transaction in flight.

Optional Feature:
- Macro: KLP32_DMEM_CLEAR_EN.
- Defined: asynchronous reset also zeroes every array word; a load after reset returns 0.
- Undefined: array has no reset and is inferred as plain RAM; contents survive reset, and power-up contents are X in simulation.

Test Plan:
- Store and load word, WAIT_STATES=1: SW 0xDEADBEEF @0x10, then LW @0x10.
  - o_rdata=0xDEADBEEF, o_err=0.
  - o_rvalid exactly 2 cycles after each accept, and high for 1 cycle.
- Byte merge and extension: SW 0x11223344 @0x20; SB 0x80 @0x21; LW @0x20.
  - LW returns 0x11228044.
  - LB @0x21 returns 0xFFFFFF80; LBU @0x21 returns 0x00000080.
- Halfword: SH 0xABCD @0x32; LH @0x32 -> 0xFFFFABCD; LHU @0x32 -> 0x0000ABCD; LW @0x30 shows bits [31:16]=0xABCD.
- Errors, each response o_err=1, o_rdata=0:
  - LW @0x22 (misaligned).
  - SH @0x33 (misaligned).
  - LW @4*DEPTH_WORDS (out of range).
  - Store funct3=100.
  - A following LW @0x20 shows the word unchanged.
- Busy and reset:
  - A second i_req held during WAIT is ignored until o_ready=1.
  - reset=0 during WAIT of SW 0x55 @0x40: outputs return to reset values immediately and no write occurs; with KLP32_DMEM_CLEAR_EN, LW @0x40 -> 0.
